dwpe_feeder: RTL and testbench

- Stage directly upstream of the depthwise PE. Buffers incoming feature-map rows for one channel plus that channel's KSIZE×KSIZE kernel.
- Per output row, streams exactly KSIZE² consecutive (pixel vector, weight) taps into the PE with an enable strobe.
- Slides the row window vertically until the channel is exhausted, then signals done.

---
 rtl/dwpe_feeder_if.sv | 43 ++++
 rtl/dwpe_feeder.sv | 250 +++++++++++++++++++++++++
 tb/tb_dwpe_feeder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwpe_feeder_if.sv
// Handshake and data bundle between the row/weight source and dwpe_feeder.
// Row width follows DWPE_FEEDER_HPAD_EN: POX when defined, POX+KSIZE-1 otherwise.
interface dwpe_feeder_if #(
    parameter int DW    = 32,
    parameter int POX   = 16,
    parameter int KSIZE = 3,
    parameter int RW    = 8
);
`ifdef DWPE_FEEDER_HPAD_EN
    localparam int ROWW = POX;
`else
    localparam int ROWW = POX + KSIZE - 1;
`endif

    logic          start;
    logic [RW-1:0] cfg_rows;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic          w_ready;
    logic          row_valid;
    logic [DW-1:0] row_data [ROWW-1:0];
    logic          row_ready;
    logic          dwpe_ena;
    logic [DW-1:0] pixel_array [POX-1:0];
    logic [DW-1:0] weight;
    logic          tap_first;
    logic          tap_last;
    logic          busy;
    logic          done;
    logic          cfg_err;

    modport master (
        output start, cfg_rows, w_valid, w_data, row_valid, row_data,
        input  w_ready, row_ready, dwpe_ena, pixel_array, weight,
               tap_first, tap_last, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_rows, w_valid, w_data, row_valid, row_data,
        output w_ready, row_ready, dwpe_ena, pixel_array, weight,
               tap_first, tap_last, busy, done, cfg_err
    );
endinterface

// File: rtl/dwpe_feeder.sv
// Depthwise PE feeder: buffers a KSIZE x KSIZE kernel and a sliding row window, streams KSIZE^2 taps per output row.
// Optional horizontal zero padding is enabled by defining DWPE_FEEDER_HPAD_EN.
module dwpe_feeder #(
    parameter int DW    = 32,
    parameter int POX   = 16,
    parameter int KSIZE = 3,
    parameter int RW    = 8
) (
    input  logic         clk,
    input  logic         rst,
    dwpe_feeder_if.slave bus
);
`ifdef DWPE_FEEDER_HPAD_EN
    localparam int ROWW = POX;
    localparam int P    = (KSIZE - 1) / 2;
`else
    localparam int ROWW = POX + KSIZE - 1;
`endif
    localparam int NT = KSIZE * KSIZE;
    localparam int NS = KSIZE + 1;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int HW = $clog2(NS);
    localparam int OW = $clog2(NS + 1);
    localparam int CW = (ROWW > 1) ? $clog2(ROWW) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_W  = 3'd1;
    localparam logic [2:0] ST_FILL    = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] cfg_rows_q, cfg_rows_d;
    logic [RW-1:0] rows_in_q, rows_in_d;
    logic [RW-1:0] out_rows_q, out_rows_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [HW-1:0] head_q, head_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [DW-1:0] w_q [NT];
    logic [DW-1:0] w_d [NT];
    logic [DW-1:0] slot_q [NS][ROWW];
    logic [DW-1:0] slot_d [NS][ROWW];

    logic          w_ready_q, w_ready_d;
    logic          row_ready_q, row_ready_d;
    logic          ena_q, ena_d;
    logic [DW-1:0] pixel_q [POX-1:0];
    logic [DW-1:0] pixel_d [POX-1:0];
    logic [DW-1:0] weight_q, weight_d;
    logic          tap_first_q, tap_first_d;
    logic          tap_last_q, tap_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;

    logic          w_acc;
    logic          r_acc;
    logic [RW-1:0] out_target;

    assign w_acc      = bus.w_valid && w_ready_q;
    assign r_acc      = bus.row_valid && row_ready_q;
    assign out_target = cfg_rows_q - RW'(KSIZE - 1);

    // Outputs are derived from the next-state view (including the row being
    // written this cycle) so every output can be a flop without adding latency.
    always_comb begin : next_state
        int unsigned wr_idx;
        int unsigned ky;
        int unsigned kx;
        int unsigned s;
`ifdef DWPE_FEEDER_HPAD_EN
        int          col;
        col = 0;
`endif
        state_d    = state_q;
        cfg_rows_d = cfg_rows_q;
        rows_in_d  = rows_in_q;
        out_rows_d = out_rows_q;
        occ_d      = occ_q;
        head_d     = head_q;
        wcnt_d     = wcnt_q;
        tap_d      = tap_q;
        w_d        = w_q;
        slot_d     = slot_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;

        wr_idx = (32'(head_q) + 32'(occ_q)) % NS;
        if (r_acc) begin
            rows_in_d = rows_in_q + RW'(1);
            for (int unsigned c = 0; c < ROWW; c++) begin
                slot_d[HW'(wr_idx)][c] = bus.row_data[c];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (int'(bus.cfg_rows) < KSIZE) begin
                        done_d    = 1'b1;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d    = ST_LOAD_W;
                        cfg_rows_d = bus.cfg_rows;
                        rows_in_d  = '0;
                        out_rows_d = '0;
                        occ_d      = '0;
                        head_d     = '0;
                        wcnt_d     = '0;
                        tap_d      = '0;
                    end
                end
            end
            ST_LOAD_W: begin
                if (w_acc) begin
                    w_d[wcnt_q] = bus.w_data;
                    if (wcnt_q == TW'(NT - 1)) begin
                        state_d = ST_FILL;
                    end else begin
                        wcnt_d = wcnt_q + TW'(1);
                    end
                end
            end
            ST_FILL: begin
                occ_d = occ_q + OW'(r_acc);
                if (occ_d >= OW'(KSIZE)) begin
                    state_d = ST_COMPUTE;
                    tap_d   = '0;
                end
            end
            ST_COMPUTE: begin
                if (tap_q == TW'(NT - 1)) begin
                    // Retire the oldest row; a same-cycle accept lands in the freed slot.
                    tap_d      = '0;
                    out_rows_d = out_rows_q + RW'(1);
                    head_d     = (head_q == HW'(NS - 1)) ? '0 : head_q + HW'(1);
                    occ_d      = occ_q + OW'(r_acc) - OW'(1);
                    if (out_rows_d == out_target) begin
                        state_d = ST_DRAIN;
                    end else if (occ_d >= OW'(KSIZE)) begin
                        state_d = ST_COMPUTE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    tap_d = tap_q + TW'(1);
                    occ_d = occ_q + OW'(r_acc);
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DRAIN) begin
            done_d = 1'b1;
        end

        busy_d      = (state_d != ST_IDLE);
        w_ready_d   = (state_d == ST_LOAD_W);
        row_ready_d = ((state_d == ST_FILL) || (state_d == ST_COMPUTE))
                      && (rows_in_d < cfg_rows_d)
                      && ((occ_d < OW'(NS))
                          || ((state_d == ST_COMPUTE) && (tap_d == TW'(NT - 1))));
        ena_d       = (state_d == ST_COMPUTE);
        tap_first_d = ena_d && (tap_d == '0);
        tap_last_d  = ena_d && (tap_d == TW'(NT - 1));
        weight_d    = ena_d ? w_d[tap_d] : '0;

        ky = 32'(tap_d) / KSIZE;
        kx = 32'(tap_d) % KSIZE;
        s  = (32'(head_d) + ky) % NS;
        for (int unsigned i = 0; i < POX; i++) begin
            pixel_d[i] = '0;
            if (ena_d) begin
`ifdef DWPE_FEEDER_HPAD_EN
                col = int'(i + kx) - P;
                if ((col >= 0) && (col < POX)) begin
                    pixel_d[i] = slot_d[HW'(s)][CW'(col)];
                end
`else
                pixel_d[i] = slot_d[HW'(s)][CW'(i + kx)];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_rows_q  <= '0;
            rows_in_q   <= '0;
            out_rows_q  <= '0;
            occ_q       <= '0;
            head_q      <= '0;
            wcnt_q      <= '0;
            tap_q       <= '0;
            w_ready_q   <= 1'b0;
            row_ready_q <= 1'b0;
            ena_q       <= 1'b0;
            pixel_q     <= '{default: '0};
            weight_q    <= '0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_rows_q  <= cfg_rows_d;
            rows_in_q   <= rows_in_d;
            out_rows_q  <= out_rows_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            wcnt_q      <= wcnt_d;
            tap_q       <= tap_d;
            w_ready_q   <= w_ready_d;
            row_ready_q <= row_ready_d;
            ena_q       <= ena_d;
            pixel_q     <= pixel_d;
            weight_q    <= weight_d;
            tap_first_q <= tap_first_d;
            tap_last_q  <= tap_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Kernel and row storage carry no reset; occupancy/head gate every read.
    always_ff @(posedge clk) begin
        w_q    <= w_d;
        slot_q <= slot_d;
    end

    assign bus.w_ready     = w_ready_q;
    assign bus.row_ready   = row_ready_q;
    assign bus.dwpe_ena    = ena_q;
    assign bus.pixel_array = pixel_q;
    assign bus.weight      = weight_q;
    assign bus.tap_first   = tap_first_q;
    assign bus.tap_last    = tap_last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_dwpe_feeder.sv
// Scoreboard bench for dwpe_feeder: expected taps queued at stimulus time, popped on each dwpe_ena.
module tb_dwpe_feeder;
    localparam int DW    = 32;
    localparam int POX   = 16;
    localparam int KSIZE = 3;
    localparam int RW    = 8;
    localparam int NT    = KSIZE * KSIZE;
`ifdef DWPE_FEEDER_HPAD_EN
    localparam int ROWW = POX;
    localparam int P    = (KSIZE - 1) / 2;
`else
    localparam int ROWW = POX + KSIZE - 1;
    localparam int P    = 0;
`endif

    typedef struct {
        logic [DW-1:0] w;
        logic          first;
        logic          last;
        logic [DW-1:0] p0;
        logic [DW-1:0] pm;
        logic [DW-1:0] pn;
    } tap_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   ena_cnt;
    int   err_cnt;
    int   first_cyc;
    int   last_cyc;
    logic prev_ena;
    int   hs_cyc [32];
    int   bstart [$];
    tap_t exp_q [$];
    tap_t mon_e;

    dwpe_feeder_if #(.DW(DW), .POX(POX), .KSIZE(KSIZE), .RW(RW)) bus ();

    dwpe_feeder #(.DW(DW), .POX(POX), .KSIZE(KSIZE), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] px(input int base, input int row, input int col);
        if ((col < 0) || (col >= ROWW)) return '0;
        return DW'(base + 100 * row + col);
    endfunction

    function automatic logic [DW-1:0] model_pix(input int base, input int b, input int t, input int lane);
        int ky;
        int kx;
        ky = t / KSIZE;
        kx = t % KSIZE;
        return px(base, b + ky, lane + kx - P);
    endfunction

    task automatic push_exp(input int rows, input int base, input int wbase);
        tap_t e;
        for (int b = 0; b < rows - KSIZE + 1; b++) begin
            for (int t = 0; t < NT; t++) begin
                e.w     = DW'(t + 1 + wbase);
                e.first = (t == 0);
                e.last  = (t == NT - 1);
                e.p0    = model_pix(base, b, t, 0);
                e.pm    = model_pix(base, b, t, POX / 2);
                e.pn    = model_pix(base, b, t, POX - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int rows);
        bus.start    = 1'b1;
        bus.cfg_rows = RW'(rows);
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic load_weights(input int wbase);
        int k;
        for (int t = 0; t < NT; t++) begin
            bus.w_data  = DW'(t + 1 + wbase);
            bus.w_valid = 1'b1;
            k = 0;
            while (!bus.w_ready && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("w_ready_wait", bus.w_ready, 1);
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic xfer_row(input int j, input int base);
        int k;
        for (int c = 0; c < ROWW; c++) bus.row_data[c] = px(base, j, c);
        bus.row_valid = 1'b1;
        k = 0;
        while (!bus.row_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("row_ready_wait", bus.row_ready, 1);
        hs_cyc[j] = cyc;
        @(negedge clk);
    endtask

    task automatic run_channel(input int rows, input int base, input int wbase,
                               input int dly_idx, input int dly, input bit busy_start);
        int nb;
        int e0;
        int k;
        nb = rows - KSIZE + 1;
        push_exp(rows, base, wbase);
        e0        = ena_cnt;
        first_cyc = -1;
        bstart.delete();
        @(negedge clk);
        pulse_start(rows);
        load_weights(wbase);
        if (busy_start) pulse_start(1);
        for (int j = 0; j < rows; j++) begin
            if (j == dly_idx) begin
                bus.row_valid = 1'b0;
                repeat (dly) @(negedge clk);
            end
            xfer_row(j, base);
        end
        bus.row_valid = 1'b0;
        k = 0;
        while (!bus.done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", bus.done, 1);
        chk("done_after_last", cyc, last_cyc + 1);
        chk("cfg_err_quiet", bus.cfg_err, 0);
        chk("ena_count", ena_cnt - e0, nb * NT);
        chk("sb_empty", exp_q.size(), 0);
        if (dly_idx < 0) chk("burst_span", last_cyc - first_cyc + 1, nb * NT);
        if (bstart.size() > 0) chk("first_latency", bstart[0], hs_cyc[KSIZE-1] + 1);
        @(negedge clk);
        chk("done_pulse_end", bus.done, 0);
        chk("busy_after", bus.busy, 0);
        chk("w_ready_after", bus.w_ready, 0);
        chk("row_ready_after", bus.row_ready, 0);
    endtask

    initial begin
        prev_ena  = 1'b0;
        ena_cnt   = 0;
        err_cnt   = 0;
        first_cyc = -1;
        last_cyc  = 0;
    end

    always @(negedge clk) begin
        if (bus.dwpe_ena) begin
            if (exp_q.size() == 0) begin
                chk("ena_unexpected", bus.dwpe_ena, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("weight", bus.weight, mon_e.w);
                chk("tap_first", bus.tap_first, mon_e.first);
                chk("tap_last", bus.tap_last, mon_e.last);
                chk("pix_lane0", bus.pixel_array[0], mon_e.p0);
                chk("pix_lane_mid", bus.pixel_array[POX/2], mon_e.pm);
                chk("pix_lane_last", bus.pixel_array[POX-1], mon_e.pn);
            end
            if (!bus.tap_first) chk("ena_gap", prev_ena, 1);
            if (bus.tap_first) bstart.push_back(cyc);
            if (bus.tap_last) last_cyc = cyc;
            if (first_cyc < 0) first_cyc = cyc;
            ena_cnt++;
        end
        if (bus.cfg_err) err_cnt++;
        prev_ena = bus.dwpe_ena;
    end

    initial begin
        int e_err;
        int n;
        int k;
        int dh;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_rows  = '0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.row_valid = 1'b0;
        for (int c = 0; c < ROWW; c++) bus.row_data[c] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ena", bus.dwpe_ena, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_w_ready", bus.w_ready, 0);
        chk("rst_row_ready", bus.row_ready, 0);
        chk("rst_weight", bus.weight, 0);
        rst = 1'b0;

        // single output row
        run_channel(3, 0, 0, -1, 0, 1'b0);

        // sliding window with prefetch; a start while busy must be ignored
        e_err = err_cnt;
        run_channel(6, 1000, 10, -1, 0, 1'b1);
        chk("busy_start_ignored", err_cnt - e_err, 0);
        chk("slide_bursts", bstart.size(), 4);

        // starvation: 4th row arrives late
        run_channel(5, 2000, 30, 3, 20, 1'b0);
        chk("starve_bursts", bstart.size(), 3);
        if (bstart.size() > 1) chk("starve_restart", bstart[1], hs_cyc[3] + 1);

        // too few rows
        @(negedge clk);
        pulse_start(2);
        chk("err_done", bus.done, 1);
        chk("err_cfg_err", bus.cfg_err, 1);
        chk("err_busy", bus.busy, 0);
        chk("err_w_ready", bus.w_ready, 0);
        @(negedge clk);
        chk("err_done_end", bus.done, 0);
        chk("err_cfg_err_end", bus.cfg_err, 0);

        // reset in the middle of a burst at tap 4
        push_exp(3, 4000, 40);
        pulse_start(3);
        load_weights(40);
        for (int j = 0; j < 3; j++) xfer_row(j, 4000);
        bus.row_valid = 1'b0;
        n = 0;
        k = 0;
        while (k < 100) begin
            if (bus.dwpe_ena) n++;
            if (n == 5) break;
            @(negedge clk);
            k++;
        end
        chk("rst_reach_tap4", n, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ena", bus.dwpe_ena, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_weight", bus.weight, 0);
        chk("mid_rst_pix", bus.pixel_array[0], 0);
        chk("mid_rst_first", bus.tap_first, 0);
        chk("mid_rst_row_ready", bus.row_ready, 0);
        chk("mid_rst_sb_left", exp_q.size(), NT - 5);
        rst = 1'b0;
        exp_q.delete();
        dh = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dh++;
        end
        chk("no_done_after_rst", dh, 0);

        run_channel(3, 5000, 50, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
